// File: rtl/conv3x3_mf_pkg.sv
// Shared definitions for the 3x3 multi-filter convolution engine.
// Holds the controller state encoding, the output-width derivation and the
// tap-index helpers that map a (row, col) window position to a tap number.
package conv3x3_mf_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoadW  = 2'd1,
    StStream = 2'd2,
    StDrain  = 2'd3
  } state_e;

  localparam int unsigned TapsPerRow = 3;
  localparam int unsigned NumTaps    = TapsPerRow * TapsPerRow;

  // Nine 2M-bit products summed need 4 extra bits of headroom.
  function automatic int unsigned calc_ow(input int unsigned m);
    return 2 * m + 4;
  endfunction

  // Tap 0 is the top-left (oldest) pixel, tap 8 the bottom-right (newest).
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
    return r * TapsPerRow + c;
  endfunction

endpackage

// File: rtl/conv3x3_linebuf.sv
// Two-row line buffer plus 3x3 window register.
// Ports:
//   clk   - clock
//   shift - accept din into the line buffer and slide the window one column
//   col   - current column of the incoming pixel (0..S-1)
//   din   - incoming pixel
//   win   - window, tap t at win[t*M +: M]
module conv3x3_linebuf import conv3x3_mf_pkg::*; #(
  parameter int unsigned M = 8,
  parameter int unsigned S = 482,
  localparam int unsigned CW = $clog2(S)
) (
  input  logic                 clk,
  input  logic                 shift,
  input  logic [CW-1:0]        col,
  input  logic [M-1:0]         din,
  output logic [NumTaps*M-1:0] win
);

  logic [M-1:0] row1_q [S];  // previous row
  logic [M-1:0] row2_q [S];  // two rows back
  logic [M-1:0] win_q  [TapsPerRow][TapsPerRow];

  // Contents are don't-care until the controller flags a valid window.
  always_ff @(posedge clk) begin
    if (shift) begin
      row2_q[col] <= row1_q[col];
      row1_q[col] <= din;
      for (int r = 0; r < TapsPerRow; r++) begin
        for (int c = 0; c < TapsPerRow - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
      win_q[0][2] <= row2_q[col];
      win_q[1][2] <= row1_q[col];
      win_q[2][2] <= din;
    end
  end

  for (genvar r = 0; r < TapsPerRow; r++) begin : g_row
    for (genvar c = 0; c < TapsPerRow; c++) begin : g_col
      assign win[tap_idx(r, c)*M +: M] = win_q[r][c];
    end
  end

endmodule

// File: rtl/conv3x3_mf.sv
// 3x3 convolution over a streamed S x S frame with NF parallel filters.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   w_start            - begin a weight load (IDLE only)
//   w_din, w_valid     - weight stream, filter 0..NF-1, tap 0..8 within each
//   frame_start        - begin a frame (IDLE with weights loaded only)
//   din, valid_in      - pixel stream, row-major, gaps allowed
//   dout, valid_out    - results, filter k at dout[k*OW +: OW]
//   frame_done         - pulses with the last valid_out of a frame
//   busy, w_loaded     - controller not idle / complete weight set held
module conv3x3_mf import conv3x3_mf_pkg::*; #(
  parameter int unsigned M    = 8,
  parameter int unsigned S    = 482,
  parameter int unsigned NF   = 2,
  parameter int unsigned RELU = 0,
  localparam int unsigned OW  = calc_ow(M)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_start,
  input  logic [M-1:0]     w_din,
  input  logic             w_valid,
  input  logic             frame_start,
  input  logic [M-1:0]     din,
  input  logic             valid_in,
  output logic [NF*OW-1:0] dout,
  output logic             valid_out,
  output logic             frame_done,
  output logic             busy,
  output logic             w_loaded
);

  localparam int unsigned CW  = $clog2(S);
  localparam int unsigned NW  = NumTaps * NF;
  localparam int unsigned WCW = $clog2(NW);
  localparam int unsigned PW  = 2 * M;

  state_e state_q, state_d;
  logic [CW-1:0]  row_q, col_q;
  logic [WCW-1:0] wcnt_q;
  logic           w_loaded_q;
  logic [M-1:0]   w_q [NW];

  logic start_load, start_frame, w_beat, accept;
  logic last_w, col_wrap, last_pix, win_vld;

  logic win_vld_q, prod_vld_q, sum_vld_q, valid_q;
  logic win_last_q, prod_last_q, sum_last_q, done_q;

  logic [NumTaps*M-1:0]  win;
  logic signed [PW-1:0]  prod_q [NW];
  logic signed [OW-1:0]  sum_d [NF];
  logic signed [OW-1:0]  sum_q [NF];
  logic [NF*OW-1:0]      relu_d, dout_q;

  assign last_w   = (wcnt_q == WCW'(NW - 1));
  assign col_wrap = (col_q == CW'(S - 1));
  assign last_pix = col_wrap && (row_q == CW'(S - 1));
  assign win_vld  = accept && (row_q >= CW'(2)) && (col_q >= CW'(2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_load)       state_d = StLoadW;
        else if (start_frame) state_d = StStream;
      end
      StLoadW:  if (w_beat && last_w)   state_d = StIdle;
      StStream: if (accept && last_pix) state_d = StDrain;
      // done_q is high during the cycle the final result is on dout.
      StDrain:  if (done_q)             state_d = StIdle;
      default:                          state_d = StIdle;
    endcase
  end

  // Output / control decode; w_start wins over frame_start in IDLE.
  always_comb begin
    start_load  = 1'b0;
    start_frame = 1'b0;
    w_beat      = 1'b0;
    accept      = 1'b0;
    case (state_q)
      StIdle: begin
        start_load  = w_start;
        start_frame = frame_start && !w_start && w_loaded_q;
      end
      StLoadW:  w_beat = w_valid;
      StStream: accept = valid_in;
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);

  // Counters, weights and load status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q     <= '0;
      w_loaded_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else begin
      if (start_load) begin
        wcnt_q     <= '0;
        w_loaded_q <= 1'b0;
      end else if (w_beat) begin
        w_q[wcnt_q] <= w_din;
        wcnt_q      <= last_w ? '0 : wcnt_q + WCW'(1);
        if (last_w) w_loaded_q <= 1'b1;
      end
      if (start_frame) begin
        row_q <= '0;
        col_q <= '0;
      end else if (accept) begin
        if (col_wrap) begin
          col_q <= '0;
          row_q <= row_q + CW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  conv3x3_linebuf #(
    .M(M),
    .S(S)
  ) u_linebuf (
    .clk  (clk),
    .shift(accept),
    .col  (col_q),
    .din  (din),
    .win  (win)
  );

  // Pipeline valid/last tracking and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_vld_q   <= 1'b0;
      win_last_q  <= 1'b0;
      prod_vld_q  <= 1'b0;
      prod_last_q <= 1'b0;
      sum_vld_q   <= 1'b0;
      sum_last_q  <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      win_vld_q   <= win_vld;
      win_last_q  <= accept && last_pix;
      prod_vld_q  <= win_vld_q;
      prod_last_q <= win_last_q;
      sum_vld_q   <= prod_vld_q;
      sum_last_q  <= prod_last_q;
      valid_q     <= sum_vld_q;
      done_q      <= sum_vld_q && sum_last_q;
      if (sum_vld_q) dout_q <= relu_d;
    end
  end

  // Datapath registers; gated by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (win_vld_q) begin
      for (int i = 0; i < NW; i++) begin
        prod_q[i] <= PW'($signed(win[(i % NumTaps)*M +: M])) * PW'($signed(w_q[i]));
      end
    end
    if (prod_vld_q) begin
      for (int k = 0; k < NF; k++) sum_q[k] <= sum_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NF; k++) begin
      sum_d[k] = '0;
      for (int t = 0; t < NumTaps; t++) begin
        sum_d[k] = sum_d[k] + OW'(prod_q[k*NumTaps + t]);
      end
    end
  end

  always_comb begin
    relu_d = '0;
    for (int k = 0; k < NF; k++) begin
      relu_d[k*OW +: OW] = ((RELU != 0) && sum_q[k][OW-1]) ? '0 : sum_q[k];
    end
  end

  assign dout       = dout_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;
  assign w_loaded   = w_loaded_q;

endmodule

// File: tb/tb_conv3x3_mf.sv
// Bench for conv3x3_mf: two instances (RELU=0 and RELU=1) share stimulus.
// Expected results are pushed when the completing pixel is accepted; a
// negedge monitor pops and compares whenever valid_out is seen.
module tb_conv3x3_mf;

  localparam int unsigned M  = 8;
  localparam int unsigned S  = 4;
  localparam int unsigned NF = 2;
  localparam int unsigned OW = 2 * M + 4;
  localparam int unsigned DW = NF * OW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_start = 1'b0, w_valid = 1'b0, frame_start = 1'b0, valid_in = 1'b0;
  logic [M-1:0] w_din = '0, din = '0;

  logic [DW-1:0] dout_a, dout_b;
  logic vo_a, vo_b, fd_a, fd_b, busy_a, busy_b, wl_a, wl_b;

  conv3x3_mf #(.M(M), .S(S), .NF(NF), .RELU(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .w_start(w_start), .w_din(w_din), .w_valid(w_valid),
    .frame_start(frame_start), .din(din), .valid_in(valid_in), .dout(dout_a),
    .valid_out(vo_a), .frame_done(fd_a), .busy(busy_a), .w_loaded(wl_a)
  );

  conv3x3_mf #(.M(M), .S(S), .NF(NF), .RELU(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .w_start(w_start), .w_din(w_din), .w_valid(w_valid),
    .frame_start(frame_start), .din(din), .valid_in(valid_in), .dout(dout_b),
    .valid_out(vo_b), .frame_done(fd_b), .busy(busy_b), .w_loaded(wl_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f0;
    int f1;
    bit last;
    int cyc;
  } exp_t;

  exp_t q [2][$];
  logic [DW-1:0] hold_exp [2];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [M-1:0] pix [16];
  logic [M-1:0] wts [18];
  int e0 [4];
  int e1 [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [OW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic mon(input int u, input logic vo, input logic fd, input logic [DW-1:0] d);
    exp_t e;
    string nm;
    nm = (u == 0) ? "relu0" : "relu1";
    if (vo) begin
      if (q[u].size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s.unexpected_valid_out: got dout=%h, expected no output", nm, d);
      end else begin
        e = q[u].pop_front();
        check({nm, ".f0"}, sx(d[OW-1:0]), e.f0);
        check({nm, ".f1"}, sx(d[2*OW-1:OW]), e.f1);
        check({nm, ".frame_done"}, fd, e.last);
        check({nm, ".latency"}, cyc - e.cyc, 3);
        hold_exp[u] = {OW'(e.f1), OW'(e.f0)};
      end
    end else begin
      check({nm, ".frame_done_idle"}, fd, 0);
      check({nm, ".dout_hold"}, d, hold_exp[u]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_exp[0] = '0;
      hold_exp[1] = '0;
    end else begin
      mon(0, vo_a, fd_a, dout_a);
      mon(1, vo_b, fd_b, dout_b);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int j, input bit last);
    exp_t e;
    e.f0 = e0[j];
    e.f1 = e1[j];
    e.last = last;
    e.cyc = cyc;
    q[0].push_back(e);
    e.f0 = (e0[j] < 0) ? 0 : e0[j];
    e.f1 = (e1[j] < 0) ? 0 : e1[j];
    q[1].push_back(e);
  endtask

  task automatic load_w(input bit with_fs);
    w_start = 1'b1;
    frame_start = with_fs;
    step();
    w_start = 1'b0;
    frame_start = 1'b0;
    if (with_fs) begin
      check("w_start_wins.busy", busy_a, 1);
      check("w_start_wins.w_loaded", wl_a, 0);
    end
    for (int i = 0; i < 18; i++) begin
      w_din = wts[i];
      w_valid = 1'b1;
      step();
      w_valid = 1'b0;
      if (i % 4 == 3) step();
    end
    check("load.w_loaded", wl_a, 1);
    check("load.w_loaded_relu", wl_b, 1);
    check("load.busy", busy_a, 0);
  endtask

  task automatic run_frame(input int gap, input bit wmid);
    int n;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("frame.busy", busy_a, 1);
    for (int i = 0; i < 16; i++) begin
      din = pix[i];
      valid_in = 1'b1;
      if (wmid && i == 5) begin
        w_start = 1'b1;
        w_valid = 1'b1;
        w_din = 8'd55;
      end
      step();
      valid_in = 1'b0;
      w_start = 1'b0;
      w_valid = 1'b0;
      if (i / 4 >= 2 && i % 4 >= 2) push((i / 4 - 2) * 2 + (i % 4 - 2), i == 15);
      for (int g = 0; g < gap; g++) step();
    end
    n = 0;
    while ((busy_a || busy_b || q[0].size() != 0 || q[1].size() != 0) && n < 30) begin
      step();
      n++;
    end
    check("frame.results_left", q[0].size() + q[1].size(), 0);
    check("frame.busy_end", busy_a, 0);
    check("frame.w_loaded_kept", wl_a, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset.dout", dout_a, 0);
    check("reset.valid_out", vo_a, 0);
    check("reset.frame_done", fd_a, 0);
    check("reset.busy", busy_a, 0);
    check("reset.w_loaded", wl_a, 0);
    rst_n = 1'b1;
    step();

    // frame_start with no weights must be ignored, as must valid_in in IDLE
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("nowts.busy", busy_a, 0);
    din = 8'd7;
    valid_in = 1'b1;
    repeat (3) step();
    valid_in = 1'b0;
    check("nowts.busy_after", busy_a, 0);
    repeat (5) step();

    // Load A: all weights 1; stray w_valid afterwards must not alter them
    for (int i = 0; i < 18; i++) wts[i] = 8'd1;
    load_w(1'b0);
    w_din = 8'd99;
    w_valid = 1'b1;
    repeat (2) step();
    w_valid = 1'b0;
    for (int i = 0; i < 16; i++) pix[i] = 8'd1;
    e0 = '{9, 9, 9, 9};
    e1 = '{9, 9, 9, 9};
    run_frame(0, 1'b0);

    // Load B: filter 0 centre tap only, filter 1 all -1
    for (int i = 0; i < 18; i++) wts[i] = (i < 9) ? ((i == 4) ? 8'd1 : 8'd0) : 8'hFF;
    load_w(1'b1);
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    e0 = '{5, 6, 9, 10};
    e1 = '{-45, -54, -81, -90};
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(0, 1'b1);
    for (int i = 0; i < 16; i++) pix[i] = 8'd127;
    e0 = '{127, 127, 127, 127};
    e1 = '{-1143, -1143, -1143, -1143};
    run_frame(0, 1'b0);

    // Load C: asymmetric taps to pin down tap and filter ordering
    for (int i = 0; i < 18; i++) wts[i] = 8'd0;
    wts[0]  = 8'd1;
    wts[10] = 8'hFF;
    wts[17] = 8'd2;
    load_w(1'b0);
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    e0 = '{0, 1, 4, 5};
    e1 = '{19, 20, 23, 24};
    run_frame(2, 1'b0);

    // Reset mid-frame with a result in flight
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      din = pix[i];
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    q[0].delete();
    q[1].delete();
    check("midrst.dout", dout_a, 0);
    check("midrst.valid_out", vo_a, 0);
    check("midrst.frame_done", fd_a, 0);
    check("midrst.busy", busy_a, 0);
    check("midrst.w_loaded", wl_a, 0);
    check("midrst.dout_relu", dout_b, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check("postrst.w_loaded", wl_a, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("postrst.busy", busy_a, 0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
